btn_event_decoder: RTL and testbench

//  Consumes the clean, debounced button level produced by the button

---
 rtl/btn_event_decoder_pkg.sv | 29 ++
 rtl/btn_event_decoder_if.sv | 12 +
 rtl/btn_evt_slot.sv | 54 +++++
 rtl/btn_event_decoder.sv | 102 ++++++++++
 tb/tb_btn_event_decoder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_event_decoder_pkg.sv
// Shared types for the button event decoder: event codes, FSM states and
// the internal event record passed from the classifier to the output slot.
package btn_event_decoder_pkg;

  typedef enum logic [1:0] {
    EVT_SHORT        = 2'b00,
    EVT_LONG         = 2'b01,
    EVT_REPEAT       = 2'b10,
    EVT_RELEASE_LONG = 2'b11
  } evt_code_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_HELD      = 2'b01,
    ST_REPEATING = 2'b10
  } state_e;

  typedef struct packed {
    logic      valid;
    evt_code_e code;
  } evt_t;

  localparam evt_t EVT_NONE = '{valid: 1'b0, code: EVT_SHORT};

  function automatic evt_t mk_evt(input evt_code_e code);
    return '{valid: 1'b1, code: code};
  endfunction

endpackage

// File: rtl/btn_event_decoder_if.sv
// Valid/ready event channel from the decoder (master) to the menu/control FSM (slave).
interface btn_event_decoder_if;
  import btn_event_decoder_pkg::*;

  logic      event_valid;
  logic      event_ready;
  evt_code_e event_code;

  modport master (output event_valid, output event_code, input event_ready);
  modport slave  (input event_valid, input event_code, output event_ready);

endinterface

// File: rtl/btn_evt_slot.sv
// One-entry valid/ready holding register. A new event is loaded when the slot
// is empty or draining this cycle; otherwise it is dropped and overflow pulses.
module btn_evt_slot
  import btn_event_decoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  evt_t                push_i,
  output logic                overflow_o,
  btn_event_decoder_if.master evt_if
);

  logic      valid_q, valid_d;
  evt_code_e code_q, code_d;
  logic      ovf_q, ovf_d;
  logic      xfer;

  assign xfer = valid_q & evt_if.event_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = 1'b0;
    if (push_i.valid) begin
      if (!valid_q || evt_if.event_ready) begin
        valid_d = 1'b1;
        code_d  = push_i.code;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= EVT_SHORT;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_if.event_valid = valid_q;
  assign evt_if.event_code  = code_q;
  assign overflow_o         = ovf_q;

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into SHORT / LONG / REPEAT / RELEASE_LONG
// events and hands them to a one-entry output slot.
module btn_event_decoder
  import btn_event_decoder_pkg::*;
#(
  parameter int LONG_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int CNT_W      = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_level,
  output logic                overflow,
  output logic                held,
  btn_event_decoder_if.master evt_if
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] REP_TH  = CNT_W'(REPEAT_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             held_q;
  logic             rise;
  evt_t             emit;

  assign rise = btn_level & ~btn_q;

  // A release always wins over a threshold hit on the same sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = EVT_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HELD;
          cnt_d   = CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!btn_level) begin
          emit    = mk_evt(EVT_SHORT);
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_TH) begin
          emit    = mk_evt(EVT_LONG);
          state_d = ST_REPEATING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REPEATING: begin
        if (!btn_level) begin
          emit    = mk_evt(EVT_RELEASE_LONG);
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (REPEAT_CYC != 0) begin
          if (cnt_q == REP_TH) begin
            emit  = mk_evt(EVT_REPEAT);
            cnt_d = CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // btn_q resets to 1 so a button held through reset must be released first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b1;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_level;
      held_q  <= (state_d != ST_IDLE);
    end
  end

  assign held = held_q;

  btn_evt_slot u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (emit),
    .overflow_o (overflow),
    .evt_if     (evt_if)
  );

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder: two instances (repeat on / repeat off),
// transferred events checked against an expected-event queue per instance.
module tb_btn_event_decoder;
  import btn_event_decoder_pkg::*;

  logic clk;
  logic rst_n;
  logic btn_a, btn_b;
  logic rdy_a, rdy_b;
  logic ovf_a, ovf_b;
  logic held_a, held_b;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_seen_a = 0;
  int ovf_seen_b = 0;

  evt_code_e q_a[$];
  evt_code_e q_b[$];

  btn_event_decoder_if if_a ();
  btn_event_decoder_if if_b ();

  assign if_a.event_ready = rdy_a;
  assign if_b.event_ready = rdy_b;

  btn_event_decoder #(.LONG_CYC(8), .REPEAT_CYC(4), .CNT_W(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_level (btn_a),
    .overflow  (ovf_a),
    .held      (held_a),
    .evt_if    (if_a)
  );

  btn_event_decoder #(.LONG_CYC(8), .REPEAT_CYC(0), .CNT_W(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_level (btn_b),
    .overflow  (ovf_b),
    .held      (held_b),
    .evt_if    (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int which, input evt_code_e c);
    if (which == 0) q_a.push_back(c);
    else            q_b.push_back(c);
  endtask

  // Events a press of n high samples must produce (LONG_CYC = 8).
  task automatic expect_press(input int which, input int n, input int rep);
    if (n <= 8) begin
      push_exp(which, EVT_SHORT);
    end else begin
      push_exp(which, EVT_LONG);
      if (rep != 0)
        for (int h = 9 + rep; h <= n; h += rep) push_exp(which, EVT_REPEAT);
      push_exp(which, EVT_RELEASE_LONG);
    end
  endtask

  task automatic press_a(input int n);
    btn_a = 1'b1;
    repeat (n) tick();
    btn_a = 1'b0;
    tick();
  endtask

  // Scoreboard: every transfer must match the next expected event.
  always @(negedge clk) begin
    if (if_a.event_valid === 1'b1 && if_a.event_ready === 1'b1) begin
      check("a_sb_has_entry", q_a.size() != 0, 1);
      if (q_a.size() != 0) check("a_evt_code", if_a.event_code, q_a.pop_front());
    end
    if (if_b.event_valid === 1'b1 && if_b.event_ready === 1'b1) begin
      check("b_sb_has_entry", q_b.size() != 0, 1);
      if (q_b.size() != 0) check("b_evt_code", if_b.event_code, q_b.pop_front());
    end
    if (ovf_a === 1'b1) ovf_seen_a++;
    if (ovf_b === 1'b1) ovf_seen_b++;
  end

  initial begin
    rst_n = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    #7;
    check("rst_valid", if_a.event_valid, 0);
    check("rst_code", if_a.event_code, EVT_SHORT);
    check("rst_ovf", ovf_a, 0);
    check("rst_held", held_a, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: three high samples -> one SHORT, valid for one cycle
    push_exp(0, EVT_SHORT);
    btn_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_held", held_a, 1);
      check("t1_no_evt", if_a.event_valid, 0);
    end
    btn_a = 1'b0;
    tick();
    check("t1_held_off", held_a, 0);
    check("t1_valid", if_a.event_valid, 1);
    check("t1_code", if_a.event_code, EVT_SHORT);
    tick();
    check("t1_valid_drop", if_a.event_valid, 0);

    // 2: 8 samples is still SHORT; 9 samples is LONG
    push_exp(0, EVT_SHORT);
    btn_a = 1'b1;
    repeat (8) tick();
    check("t2_h8_no_long", if_a.event_valid, 0);
    btn_a = 1'b0;
    tick();
    check("t2_short_code", if_a.event_code, EVT_SHORT);
    tick();
    expect_press(0, 9, 4);
    btn_a = 1'b1;
    repeat (8) tick();
    check("t2_pre_long", if_a.event_valid, 0);
    tick();
    check("t2_long_valid", if_a.event_valid, 1);
    check("t2_long_code", if_a.event_code, EVT_LONG);
    btn_a = 1'b0;
    tick();
    check("t2_rel_valid", if_a.event_valid, 1);
    check("t2_rel_code", if_a.event_code, EVT_RELEASE_LONG);
    tick();
    check("t2_idle", if_a.event_valid, 0);

    // 3: repeats at H=13,17,21; release at H=25 coincidence gives only RELEASE_LONG
    expect_press(0, 21, 4);
    btn_a = 1'b1;
    repeat (12) tick();
    check("t3_h12_quiet", if_a.event_valid, 0);
    tick();
    check("t3_h13_code", if_a.event_code, EVT_REPEAT);
    check("t3_h13_valid", if_a.event_valid, 1);
    repeat (8) tick();
    check("t3_h21_code", if_a.event_code, EVT_REPEAT);
    btn_a = 1'b0;
    tick();
    check("t3_rel_code", if_a.event_code, EVT_RELEASE_LONG);
    tick();
    expect_press(0, 24, 4);
    press_a(24);
    check("t3_coinc_valid", if_a.event_valid, 1);
    check("t3_coinc_code", if_a.event_code, EVT_RELEASE_LONG);
    tick();

    // 4: backpressure: pending SHORT survives, new events dropped with overflow pulse
    rdy_a = 1'b0;
    push_exp(0, EVT_SHORT);
    press_a(2);
    check("t4_pending", if_a.event_valid, 1);
    check("t4_ovf_none", ovf_a, 0);
    tick();
    btn_a = 1'b1;
    repeat (9) tick();
    check("t4_ovf_long", ovf_a, 1);
    check("t4_code_kept", if_a.event_code, EVT_SHORT);
    tick();
    check("t4_ovf_pulse", ovf_a, 0);
    btn_a = 1'b0;
    tick();
    check("t4_ovf_rel", ovf_a, 1);
    tick();
    check("t4_ovf_rel_end", ovf_a, 0);
    check("t4_code_kept2", if_a.event_code, EVT_SHORT);
    rdy_a = 1'b1;
    tick();
    check("t4_drained", if_a.event_valid, 0);

    // 5: async reset mid-hold with a LONG pending; held-through-reset press is ignored
    rdy_a = 1'b0;
    btn_a = 1'b1;
    repeat (9) tick();
    check("t5_long_pending", if_a.event_code, EVT_LONG);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", if_a.event_valid, 0);
    check("t5_rst_code", if_a.event_code, EVT_SHORT);
    check("t5_rst_held", held_a, 0);
    check("t5_rst_ovf", ovf_a, 0);
    tick();
    rst_n = 1'b1;
    rdy_a = 1'b1;
    repeat (12) tick();
    check("t5_still_high_valid", if_a.event_valid, 0);
    check("t5_still_high_held", held_a, 0);
    btn_a = 1'b0;
    tick();
    check("t5_release_quiet", if_a.event_valid, 0);
    push_exp(0, EVT_SHORT);
    btn_a = 1'b1;
    tick();
    check("t5_repress_held", held_a, 1);
    tick();
    btn_a = 1'b0;
    tick();
    check("t5_short", if_a.event_valid, 1);
    tick();

    // 6: repeat disabled: only LONG and RELEASE_LONG; back-to-back without bubble
    expect_press(1, 30, 0);
    btn_b = 1'b1;
    repeat (9) tick();
    check("t6_long", if_b.event_code, EVT_LONG);
    repeat (21) tick();
    check("t6_no_repeat", if_b.event_valid, 0);
    check("t6_held", held_b, 1);
    btn_b = 1'b0;
    tick();
    check("t6_rel", if_b.event_code, EVT_RELEASE_LONG);
    tick();
    expect_press(1, 9, 0);
    btn_b = 1'b1;
    repeat (9) tick();
    check("t6_b2b_long", if_b.event_code, EVT_LONG);
    btn_b = 1'b0;
    tick();
    check("t6_b2b_valid", if_b.event_valid, 1);
    check("t6_b2b_code", if_b.event_code, EVT_RELEASE_LONG);
    check("t6_b2b_ovf", ovf_b, 0);
    tick();
    check("t6_b2b_drop", if_b.event_valid, 0);

    repeat (3) tick();
    check("end_q_a_empty", q_a.size(), 0);
    check("end_q_b_empty", q_b.size(), 0);
    check("end_ovf_a_count", ovf_seen_a, 2);
    check("end_ovf_b_count", ovf_seen_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
